// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage load/store unit for the RISC-V pipeline.
//
// Replaces a single-cycle combinational memory access with a request/acknowledge
// data-memory handshake that tolerates wait states. It builds byte enables and
// lane-replicated store data, and aligns and zero/sign-extends load data.
//
// Compile-time option:
//   LSU_TIMEOUT_EN  when defined, BUSY gives up after MAX_WAIT cycles without
//                   mem_ack and pulses timeout_err; otherwise BUSY waits forever
//                   and timeout_err stays 0.
//
// Ports:
//   clk, int_rst_n          clock, asynchronous active-low reset
//   halt                    pipeline halt: blocks acceptance, holds the response
//   req_valid/op/type       memory-stage operation (op 00 load, 01 store)
//   req_addr, req_wdata     byte address and right-justified store data
//   stall                   hold upstream pipeline registers
//   mem_req/we/addr/be/wdata  data-memory request (level, held until ack)
//   mem_rdata, mem_ack      read data and one-cycle completion
//   rsp_valid, rsp_rdata    completion and aligned/extended load result
//   misalign_err            one-cycle pulse after a misaligned request
//   timeout_err             one-cycle pulse after a memory timeout
module lsu_stage #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                int_rst_n,
  input  logic                halt,
  input  logic                req_valid,
  input  logic [1:0]          req_op,
  input  logic [2:0]          req_type,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                misalign_err,
  output logic                timeout_err
);

  localparam int LANES = XLEN / 8;
  localparam int LB    = $clog2(LANES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Byte-enable mask: a run of 'size' ones starting at lane 'off'.
  function automatic logic [LANES-1:0] byte_enables(input logic [2:0] typ,
                                                    input logic [LB-1:0] off);
    logic [LANES-1:0] be;
    int size;
    int base;
    base = int'(off);
    case (typ)
      3'b000:         size = 4;
      3'b001, 3'b010: size = 2;
      3'b011, 3'b100: size = 1;
      3'b101:         size = LANES;
      default:        size = 0;
    endcase
    for (int i = 0; i < LANES; i++) begin
      be[i] = (i >= base) && (i < base + size);
    end
    return be;
  endfunction

  // Replicate the low byte/half/word across every lane; doubleword passes through.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] typ,
                                                 input logic [XLEN-1:0] data);
    logic [XLEN-1:0] res;
    case (typ)
      3'b011, 3'b100: res = {LANES{data[7:0]}};
      3'b001, 3'b010: res = {(LANES/2){data[15:0]}};
      3'b000:         res = {(LANES/4){data[31:0]}};
      default:        res = data;
    endcase
    return res;
  endfunction

  // Natural alignment check on the low three address bits.
  function automatic logic is_aligned(input logic [2:0] typ, input logic [2:0] lo);
    logic ok;
    case (typ)
      3'b000:         ok = (lo[1:0] == 2'b00);
      3'b001, 3'b010: ok = (lo[0] == 1'b0);
      3'b101:         ok = (lo == 3'b000);
      default:        ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Shift the addressed lanes down to bit 0, then zero- or sign-extend.
  // Sign extension pushes the field to the top and shifts arithmetically back.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] raw,
                                                 input logic [LB-1:0]   off,
                                                 input logic [2:0]      typ);
    logic [XLEN-1:0]        sh;
    logic signed [XLEN-1:0] sx;
    logic [XLEN-1:0]        res;
    sh = raw >> {off, 3'b000};
    sx = {XLEN{1'b0}};
    case (typ)
      3'b000: begin
        sx  = sh << (XLEN - 32);
        res = sx >>> (XLEN - 32);
      end
      3'b001: res = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b010: begin
        sx  = sh << (XLEN - 16);
        res = sx >>> (XLEN - 16);
      end
      3'b011: res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b100: begin
        sx  = sh << (XLEN - 8);
        res = sx >>> (XLEN - 8);
      end
      default: res = sh;
    endcase
    return res;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_n;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [LANES-1:0]  mem_be_r;
  logic [XLEN-1:0]   mem_wdata_r;
  logic [2:0]        type_r;
  logic [LB-1:0]     off_r;
  logic              rsp_valid_r;
  logic [XLEN-1:0]   rsp_rdata_r;
  logic              misalign_r;
  logic              timeout_r;

  logic op_ok_s;
  logic type_ok_s;
  logic aligned_s;
  logic cand_s;
  logic accept_s;
  logic misalign_s;
  logic timeout_hit_s;

  // Address bits above the data-memory window are not decoded.
  logic addr_hi_unused_s;
  assign addr_hi_unused_s = ^req_addr[XLEN-1:ADDR_W];

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt_r;

  // Timeout fires on the MAX_WAIT-th BUSY cycle; a same-cycle ack takes priority.
  always_comb begin
    timeout_hit_s = 1'b0;
    if ((state_r == BUSY) && !mem_ack && (wait_cnt_r == CW'(MAX_WAIT - 1))) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // BUSY cycle counter, zero on entry to BUSY.
  always_ff @(posedge clk or negedge int_rst_n) begin
    if (!int_rst_n) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if ((state_r == BUSY) && (state_n == BUSY)) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_r <= {CW{1'b0}};
    end
  end
`else
  // Timeout logic not built; the parameter is kept so instantiations stay uniform.
  localparam int MAX_WAIT_UNUSED = MAX_WAIT;
  assign timeout_hit_s = 1'b0;
`endif

  // Request decode: legality, alignment, acceptance and misalignment.
  always_comb begin
    op_ok_s = (req_op == 2'b00) || (req_op == 2'b01);
    if (req_type <= 3'b100) begin
      type_ok_s = 1'b1;
    end else if (req_type == 3'b101) begin
      type_ok_s = (XLEN == 64);
    end else begin
      type_ok_s = 1'b0;
    end
    aligned_s  = is_aligned(req_type, req_addr[2:0]);
    cand_s     = (state_r == IDLE) && req_valid && !halt && op_ok_s && type_ok_s;
    accept_s   = cand_s && aligned_s;
    misalign_s = cand_s && !aligned_s;
  end

  // Next-state logic for IDLE -> BUSY -> RESP -> IDLE.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_n = BUSY;
        else          state_n = IDLE;
      end
      BUSY: begin
        if (mem_ack || timeout_hit_s) state_n = RESP;
        else                          state_n = BUSY;
      end
      RESP: begin
        if (!halt) state_n = IDLE;
        else       state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, request registers and response capture.
  always_ff @(posedge clk or negedge int_rst_n) begin
    if (!int_rst_n) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= {LANES{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
      type_r      <= 3'b000;
      off_r       <= {LB{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {XLEN{1'b0}};
      misalign_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      mem_req_r   <= (state_n == BUSY);
      rsp_valid_r <= (state_n == RESP);
      misalign_r  <= misalign_s;
      timeout_r   <= timeout_hit_s;
      if (accept_s) begin
        mem_we_r    <= (req_op == 2'b01);
        mem_addr_r  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
        mem_be_r    <= byte_enables(req_type, req_addr[LB-1:0]);
        mem_wdata_r <= lane_wdata(req_type, req_wdata);
        type_r      <= req_type;
        off_r       <= req_addr[LB-1:0];
      end
      if ((state_r == BUSY) && mem_ack) begin
        rsp_rdata_r <= mem_we_r ? {XLEN{1'b0}} : align_load(mem_rdata, off_r, type_r);
      end else if (timeout_hit_s) begin
        rsp_rdata_r <= {XLEN{1'b0}};
      end
    end
  end

  // Stall must rise in the accept cycle itself, so it is combinational;
  // gating with reset keeps it low while reset is asserted.
  assign stall = int_rst_n &
                 (accept_s | (state_r == BUSY) | ((state_r == RESP) & halt));

  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_be       = mem_be_r;
  assign mem_wdata    = mem_wdata_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign misalign_err = misalign_r;
  assign timeout_err  = timeout_r;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed testbench for lsu_stage (XLEN=32, ADDR_W=16, MAX_WAIT=15).
module tb_lsu_stage;
  localparam int XLEN     = 32;
  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        int_rst_n;
  logic        halt;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [89:0] all_out;
  assign all_out = {stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    rsp_valid, rsp_rdata, misalign_err, timeout_err};

  always #5 clk = ~clk;

  lsu_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .int_rst_n(int_rst_n), .halt(halt),
    .req_valid(req_valid), .req_op(req_op), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_op = op; req_type = typ; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic clear_req();
    req_valid = 1'b0; req_op = 2'b11; req_type = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic test_reset();
    drive_req(2'b00, 3'b000, 32'h0, 32'h0);
    tick(); tick(); #1;
    checks++; if (all_out !== 90'd0) begin failures++; $display("FAIL rst_outputs got=%h exp=0", all_out); end
    clear_req();
    int_rst_n = 1'b1;
    tick(); #1;
    checks++; if (all_out !== 90'd0) begin failures++; $display("FAIL rst_idle got=%h exp=0", all_out); end
  endtask

  task automatic test_signed_byte_load();
    int stall_cnt;
    stall_cnt = 0;
    tick(); drive_req(2'b00, 3'b100, 32'h0000_0013, 32'h0); #1;
    if (stall === 1'b1) stall_cnt++;
    for (int c = 1; c <= 4; c++) begin
      tick(); clear_req();
      mem_ack   = (c == 4) ? 1'b1 : 1'b0;
      mem_rdata = (c == 4) ? 32'h80FF_7F01 : 32'h0;
      #1;
      if (stall === 1'b1) stall_cnt++;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_mem_req cyc=%0d got=%b exp=1", c, mem_req); end
      if (c == 1) begin
        checks++; if (mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", mem_be); end
        checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL sb_addr got=%h exp=0010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL sb_we got=%b exp=0", mem_we); end
      end
    end
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    if (stall === 1'b1) stall_cnt++;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL sb_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL sb_rdata got=%h exp=ffffff80", rsp_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sb_req_fall got=%b exp=0", mem_req); end
    tick(); #1;
    if (stall === 1'b1) stall_cnt++;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sb_rsp_end got=%b exp=0", rsp_valid); end
    checks++; if (stall_cnt != 5) begin failures++; $display("FAIL sb_stall_cycles got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_load_types();
    logic [2:0]  typ_v [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b010};
    logic [15:0] adr_v [6] = '{16'h0012, 16'h0012, 16'h0011, 16'h0012, 16'h0104, 16'h0010};
    logic [31:0] rd_v  [6] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                               32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_7FFE};
    logic [3:0]  be_v  [6] = '{4'b1100, 4'b1100, 4'b0010, 4'b0100, 4'b1111, 4'b0011};
    logic [31:0] exp_v [6] = '{32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_007F,
                               32'hFFFF_FFFF, 32'h80FF_7F01, 32'h0000_7FFE};
    for (int i = 0; i < 6; i++) begin
      tick(); drive_req(2'b00, typ_v[i], {16'h0, adr_v[i]}, 32'h0); #1;
      tick(); clear_req(); mem_ack = 1'b1; mem_rdata = rd_v[i]; #1;
      checks++; if (mem_be !== be_v[i]) begin failures++; $display("FAIL ld_be[%0d] got=%b exp=%b", i, mem_be, be_v[i]); end
      checks++; if (mem_addr !== {adr_v[i][15:2], 2'b00}) begin failures++; $display("FAIL ld_addr[%0d] got=%h exp=%h", i, mem_addr, {adr_v[i][15:2], 2'b00}); end
      tick(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ld_valid[%0d] got=%b exp=1", i, rsp_valid); end
      checks++; if (rsp_rdata !== exp_v[i]) begin failures++; $display("FAIL ld_rdata[%0d] got=%h exp=%h", i, rsp_rdata, exp_v[i]); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  typ_v [3] = '{3'b001, 3'b011, 3'b000};
    logic [15:0] adr_v [3] = '{16'h0022, 16'h0003, 16'h0030};
    logic [31:0] wd_v  [3] = '{32'h1234_ABCD, 32'h0000_00A5, 32'hCAFE_F00D};
    logic [3:0]  be_v  [3] = '{4'b1100, 4'b1000, 4'b1111};
    logic [31:0] exp_v [3] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      tick(); drive_req(2'b01, typ_v[i], {16'h0, adr_v[i]}, wd_v[i]); #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL st_stall[%0d] got=%b exp=1", i, stall); end
      tick(); clear_req(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
      checks++; if ({mem_req, mem_we} !== 2'b11) begin failures++; $display("FAIL st_req_we[%0d] got=%b exp=11", i, {mem_req, mem_we}); end
      checks++; if (mem_be !== be_v[i]) begin failures++; $display("FAIL st_be[%0d] got=%b exp=%b", i, mem_be, be_v[i]); end
      checks++; if (mem_wdata !== exp_v[i]) begin failures++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, mem_wdata, exp_v[i]); end
      checks++; if (mem_addr !== {adr_v[i][15:2], 2'b00}) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, mem_addr, {adr_v[i][15:2], 2'b00}); end
      tick(); mem_ack = 1'b0; #1;
      checks++; if ({rsp_valid, stall} !== 2'b10) begin failures++; $display("FAIL st_rsp[%0d] got=%b exp=10", i, {rsp_valid, stall}); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL st_rdata[%0d] got=%h exp=0", i, rsp_rdata); end
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  typ_v [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] adr_v [3] = '{32'h0000_0005, 32'h0000_0013, 32'h0000_0021};
    for (int i = 0; i < 3; i++) begin
      tick(); drive_req(2'b00, typ_v[i], adr_v[i], 32'h0); #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall0[%0d] got=%b exp=0", i, stall); end
      tick(); clear_req(); #1;
      checks++; if ({misalign_err, mem_req, stall} !== 3'b100) begin failures++; $display("FAIL mis_pulse[%0d] got=%b exp=100", i, {misalign_err, mem_req, stall}); end
      tick(); #1;
      checks++; if ({misalign_err, mem_req} !== 2'b00) begin failures++; $display("FAIL mis_end[%0d] got=%b exp=00", i, {misalign_err, mem_req}); end
    end
  endtask

  task automatic test_nop_idle();
    logic [1:0]  op_v  [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [2:0]  typ_v [5] = '{3'b000, 3'b101, 3'b111, 3'b000, 3'b000};
    logic [31:0] adr_v [5] = '{32'h0, 32'h1, 32'h3, 32'h0, 32'h5};
    logic        h_v   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tick(); drive_req(op_v[i], typ_v[i], adr_v[i], 32'h0); halt = h_v[i]; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nop_stall[%0d] got=%b exp=0", i, stall); end
      tick(); clear_req(); halt = 1'b0; #1;
      checks++; if ({mem_req, misalign_err, rsp_valid} !== 3'b000) begin failures++; $display("FAIL nop_quiet[%0d] got=%b exp=000", i, {mem_req, misalign_err, rsp_valid}); end
    end
    tick(); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
    tick(); mem_ack = 1'b0; #1;
    checks++; if ({mem_req, rsp_valid} !== 2'b00) begin failures++; $display("FAIL idle_ack got=%b exp=00", {mem_req, rsp_valid}); end
  endtask

  task automatic test_halt_resp();
    tick(); drive_req(2'b00, 3'b000, 32'h0000_0040, 32'h0); #1;
    tick(); clear_req(); halt = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1122_3344; #1;
    checks++; if ({mem_req, stall} !== 2'b11) begin failures++; $display("FAIL hl_busy got=%b exp=11", {mem_req, stall}); end
    for (int k = 0; k < 4; k++) begin
      tick(); mem_ack = 1'b0; #1;
      checks++; if ({rsp_valid, stall, mem_req} !== 3'b110) begin failures++; $display("FAIL hl_hold[%0d] got=%b exp=110", k, {rsp_valid, stall, mem_req}); end
      checks++; if (rsp_rdata !== 32'h1122_3344) begin failures++; $display("FAIL hl_rdata[%0d] got=%h exp=11223344", k, rsp_rdata); end
    end
    tick(); halt = 1'b0; drive_req(2'b00, 3'b000, 32'h0000_0050, 32'h0); #1;
    checks++; if ({rsp_valid, stall} !== 2'b10) begin failures++; $display("FAIL hl_release got=%b exp=10", {rsp_valid, stall}); end
    tick(); #1;
    checks++; if ({rsp_valid, mem_req, stall} !== 3'b001) begin failures++; $display("FAIL hl_idle_accept got=%b exp=001", {rsp_valid, mem_req, stall}); end
    tick(); clear_req(); mem_ack = 1'b1; mem_rdata = 32'h5566_7788; #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0050}) begin failures++; $display("FAIL hl_next_req got=%b/%h exp=1/0050", mem_req, mem_addr); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if (rsp_rdata !== 32'h5566_7788) begin failures++; $display("FAIL hl_next_rdata got=%h exp=55667788", rsp_rdata); end
    tick(); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL hl_single_idle got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_wait_limit();
`ifdef LSU_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      tick(); drive_req(2'b00, 3'b000, 32'h0000_0060, 32'h0); #1;
      for (int c = 1; c <= MAX_WAIT; c++) begin
        tick(); clear_req();
        mem_ack = (r == 1 && c == MAX_WAIT) ? 1'b1 : 1'b0;
        mem_rdata = 32'h0BAD_F00D; #1;
        checks++; if ({mem_req, timeout_err} !== 2'b10) begin failures++; $display("FAIL to_busy[%0d.%0d] got=%b exp=10", r, c, {mem_req, timeout_err}); end
      end
      tick(); mem_ack = 1'b0; #1;
      checks++; if ({rsp_valid, mem_req} !== 2'b10) begin failures++; $display("FAIL to_resp[%0d] got=%b exp=10", r, {rsp_valid, mem_req}); end
      checks++; if (timeout_err !== ((r == 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL to_err[%0d] got=%b exp=%b", r, timeout_err, (r == 0)); end
      checks++; if (rsp_rdata !== ((r == 0) ? 32'h0 : 32'h0BAD_F00D)) begin failures++; $display("FAIL to_rdata[%0d] got=%h", r, rsp_rdata); end
      tick(); #1;
      checks++; if ({timeout_err, rsp_valid} !== 2'b00) begin failures++; $display("FAIL to_end[%0d] got=%b exp=00", r, {timeout_err, rsp_valid}); end
    end
`else
    tick(); drive_req(2'b00, 3'b000, 32'h0000_0060, 32'h0); #1;
    for (int c = 1; c <= 20; c++) begin
      tick(); clear_req(); #1;
      checks++; if ({mem_req, stall, timeout_err} !== 3'b110) begin failures++; $display("FAIL wt_busy[%0d] got=%b exp=110", c, {mem_req, stall, timeout_err}); end
    end
    tick(); mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    tick(); mem_ack = 1'b0; #1;
    checks++; if ({rsp_valid, timeout_err} !== 2'b10) begin failures++; $display("FAIL wt_resp got=%b exp=10", {rsp_valid, timeout_err}); end
    checks++; if (rsp_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL wt_rdata got=%h exp=0badf00d", rsp_rdata); end
    tick(); #1;
`endif
  endtask

  task automatic test_reset_mid_busy();
    tick(); drive_req(2'b00, 3'b000, 32'h0000_0070, 32'h0); #1;
    tick(); clear_req(); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rb_busy got=%b exp=1", mem_req); end
    tick(); int_rst_n = 1'b0; drive_req(2'b00, 3'b000, 32'h0000_0074, 32'h0); #1;
    checks++; if ({mem_req, stall, rsp_valid} !== 3'b000) begin failures++; $display("FAIL rb_async got=%b exp=000", {mem_req, stall, rsp_valid}); end
    tick(); #1;
    checks++; if (all_out !== 90'd0) begin failures++; $display("FAIL rb_all_zero got=%h exp=0", all_out); end
    tick(); clear_req(); int_rst_n = 1'b1; #1;
    tick(); drive_req(2'b00, 3'b011, 32'h0000_000A, 32'h0); #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rb_new_stall got=%b exp=1", stall); end
    tick(); clear_req(); mem_ack = 1'b1; mem_rdata = 32'h00AB_0000; #1;
    checks++; if ({mem_be, mem_addr} !== {4'b0100, 16'h0008}) begin failures++; $display("FAIL rb_new_req got=%b/%h exp=0100/0008", mem_be, mem_addr); end
    tick(); mem_ack = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_00AB}) begin failures++; $display("FAIL rb_new_rsp got=%b/%h exp=1/000000ab", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    int_rst_n = 1'b0;
    halt      = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    clear_req();
    test_reset();
    test_signed_byte_load();
    test_load_types();
    test_stores();
    test_misalign();
    test_nop_idle();
    test_halt_resp();
    test_wait_limit();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
